// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// One operation in flight: IDLE accepts, EXEC holds operands for SETTLE cycles, RESP holds the result.
module alu_arbiter #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_opcode,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_opcode,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic [2:0] alu_opcode,
  output logic [3:0] alu_operand_a,
  output logic [3:0] alu_operand_b,
  input  logic [3:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_result,
  output logic       rsp_dz,
  output logic       busy
);

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);
  localparam logic [2:0] OP_DIV   = 3'b010;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

  state_t     r_state;
  logic       r_last;
  logic [3:0] r_cnt;
  logic       r_id;
  logic [2:0] r_op;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic       r_rsp_valid;
  logic       r_rsp_id;
  logic [3:0] r_rsp_result;
  logic       r_rsp_dz;

  logic       w_any;
  logic       w_gnt;
  logic       w_accept;
  logic       w_dz;

  // On a tie the requester not granted last wins; a lone requester always wins.
  assign w_any    = req0_valid | req1_valid;
  assign w_gnt    = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  assign w_accept = (r_state == ST_IDLE) && w_any;
  assign w_dz     = (r_op == OP_DIV) && (r_b == 4'd0);

  assign req0_ready    = w_accept && !w_gnt;
  assign req1_ready    = w_accept && w_gnt;
  assign alu_opcode    = r_op;
  assign alu_operand_a = r_a;
  assign alu_operand_b = r_b;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_id        = r_rsp_id;
  assign rsp_result    = r_rsp_result;
  assign rsp_dz        = r_rsp_dz;
  assign busy          = (r_state != ST_IDLE);

  // The operand registers double as the ALU drive, so they are zeroed outside EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last       <= 1'b1;
      r_cnt        <= 4'd0;
      r_id         <= 1'b0;
      r_op         <= 3'd0;
      r_a          <= 4'd0;
      r_b          <= 4'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= 4'd0;
      r_rsp_dz     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_EXEC;
            r_last  <= w_gnt;
            r_id    <= w_gnt;
            r_cnt   <= 4'd0;
            r_op    <= w_gnt ? req1_opcode : req0_opcode;
            r_a     <= w_gnt ? req1_a : req0_a;
            r_b     <= w_gnt ? req1_b : req0_b;
          end
        end
        ST_EXEC: begin
          if (r_cnt == LAST_CNT) begin
            r_state      <= ST_RESP;
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= r_id;
            r_rsp_result <= w_dz ? 4'd0 : alu_result;
            r_rsp_dz     <= w_dz;
            r_op         <= 3'd0;
            r_a          <= 4'd0;
            r_b          <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one SETTLE=1 instance for function/arbitration/reset,
// one SETTLE=3 instance for the longer hold window.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0] req0_opcode, req1_opcode, alu_opcode;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] alu_operand_a, alu_operand_b, alu_result, rsp_result;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_dz, busy;

  logic       s3_req0_valid, s3_req1_valid, s3_req0_ready, s3_req1_ready;
  logic [2:0] s3_req0_opcode, s3_req1_opcode, s3_alu_opcode;
  logic [3:0] s3_req0_a, s3_req0_b, s3_req1_a, s3_req1_b;
  logic [3:0] s3_alu_operand_a, s3_alu_operand_b, s3_alu_result, s3_rsp_result;
  logic       s3_rsp_valid, s3_rsp_ready, s3_rsp_id, s3_rsp_dz, s3_busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference for the external shared ALU; divide-by-zero returns junk on purpose.
  function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] prod;
    prod = {4'd0, a} * {4'd0, b};
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return (b == 4'd0) ? 4'hF : a / b;
      3'b011:  return prod[3:0];
      3'b100:  return a & b;
      3'b101:  return a | b;
      3'b110:  return ~a;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result    = alu_f(alu_opcode, alu_operand_a, alu_operand_b);
  assign s3_alu_result = alu_f(s3_alu_opcode, s3_alu_operand_a, s3_alu_operand_b);

  alu_arbiter #(.SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_opcode(alu_opcode), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_dz(rsp_dz), .busy(busy)
  );

  alu_arbiter #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(s3_req0_valid), .req0_ready(s3_req0_ready), .req0_opcode(s3_req0_opcode),
    .req0_a(s3_req0_a), .req0_b(s3_req0_b),
    .req1_valid(s3_req1_valid), .req1_ready(s3_req1_ready), .req1_opcode(s3_req1_opcode),
    .req1_a(s3_req1_a), .req1_b(s3_req1_b),
    .alu_opcode(s3_alu_opcode), .alu_operand_a(s3_alu_operand_a), .alu_operand_b(s3_alu_operand_b),
    .alu_result(s3_alu_result),
    .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready), .rsp_id(s3_rsp_id),
    .rsp_result(s3_rsp_result), .rsp_dz(s3_rsp_dz), .busy(s3_busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One complete transaction on the SETTLE=1 instance with rsp_ready held high.
  task automatic run_op(input logic id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_res, input logic exp_dz, input string tag);
    int lat;
    @(posedge clk); #1;
    if (id) begin
      req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b;
    end
    @(negedge clk);
    chk({tag, "_rdy0"}, int'(req0_ready), int'(!id));
    chk({tag, "_rdy1"}, int'(req1_ready), int'(id));
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    chk({tag, "_busy"}, int'(busy), 1);
    chk({tag, "_aluop"}, int'(alu_opcode), int'(op));
    chk({tag, "_alua"}, int'(alu_operand_a), int'(a));
    chk({tag, "_alub"}, int'(alu_operand_b), int'(b));
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_id"}, int'(rsp_id), int'(id));
    chk({tag, "_res"}, int'(rsp_result), int'(exp_res));
    chk({tag, "_dz"}, int'(rsp_dz), int'(exp_dz));
    $display("op %s: id=%0d result=%0d dz=%0d latency=%0d", tag, rsp_id, rsp_result, rsp_dz, lat);
    @(posedge clk); #1;
  endtask

  initial begin
    int gq[4];
    int rq[4];
    int ng, nr, seen;
    logic [3:0] held;

    rst_n = 1'b0;
    req0_valid = 0; req0_opcode = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_opcode = 0; req1_a = 0; req1_b = 0;
    rsp_ready = 1'b1;
    s3_req0_valid = 0; s3_req0_opcode = 0; s3_req0_a = 0; s3_req0_b = 0;
    s3_req1_valid = 0; s3_req1_opcode = 0; s3_req1_a = 0; s3_req1_b = 0;
    s3_rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_aluop", int'(alu_opcode), 0);
    chk("rst_result", int'(rsp_result), 0);
    chk("rst_dz", int'(rsp_dz), 0);
    chk("rst_id", int'(rsp_id), 0);
    $display("reset: rsp_valid=%0d busy=%0d", rsp_valid, busy);
    @(posedge clk); #1 rst_n = 1'b1;

    run_op(1'b0, 3'b000, 4'd3,  4'd4,  4'd7,  1'b0, "add");
    run_op(1'b1, 3'b010, 4'd9,  4'd0,  4'd0,  1'b1, "div0");
    run_op(1'b1, 3'b010, 4'd9,  4'd2,  4'd4,  1'b0, "div");
    run_op(1'b0, 3'b001, 4'd3,  4'd5,  4'd14, 1'b0, "sub");
    run_op(1'b0, 3'b011, 4'd5,  4'd5,  4'd9,  1'b0, "mul");
    run_op(1'b1, 3'b110, 4'd5,  4'd0,  4'd10, 1'b0, "nota");
    run_op(1'b0, 3'b100, 4'hC,  4'hA,  4'd8,  1'b0, "and");
    run_op(1'b1, 3'b101, 4'hC,  4'hA,  4'd14, 1'b0, "or");
    run_op(1'b0, 3'b111, 4'hC,  4'hA,  4'd6,  1'b0, "xor");

    // Round robin from reset with both requesters always valid.
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1; req0_opcode = 3'b000; req0_a = 4'd1; req0_b = 4'd1;
    req1_valid = 1; req1_opcode = 3'b000; req1_a = 4'd2; req1_b = 4'd2;
    ng = 0; nr = 0;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      @(negedge clk);
      if (req0_ready && ng < 4) begin gq[ng] = 0; ng++; end
      if (req1_ready && ng < 4) begin gq[ng] = 1; ng++; end
      if (rsp_valid && nr < 4) begin rq[nr] = int'(rsp_id); nr++; end
    end
    req0_valid = 0;
    req1_valid = 0;
    chk("rr_ngrants", ng, 4);
    chk("rr_nrsp", nr, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ng) chk($sformatf("rr_grant%0d", i), gq[i], i % 2);
      if (i < nr) chk($sformatf("rr_rspid%0d", i), rq[i], i % 2);
      $display("rr %0d: grant=%0d rsp_id=%0d", i, (i < ng) ? gq[i] : -1, (i < nr) ? rq[i] : -1);
    end
    @(posedge clk); #1;

    // Consumer stall: response must hold while req1 waits unserved.
    rsp_ready = 1'b0;
    req0_valid = 1; req0_opcode = 3'b101; req0_a = 4'd3; req0_b = 4'd5;
    @(negedge clk);
    chk("stall_rdy0", int'(req0_ready), 1);
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 1;
    seen = 0;
    for (int c = 0; c < 20 && !rsp_valid; c++) @(negedge clk);
    held = rsp_result;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_valid", i), int'(rsp_valid), 1);
      chk($sformatf("stall%0d_res", i), int'(rsp_result), 7);
      chk($sformatf("stall%0d_rdy0", i), int'(req0_ready), 0);
      chk($sformatf("stall%0d_rdy1", i), int'(req1_ready), 0);
      chk($sformatf("stall%0d_busy", i), int'(busy), 1);
      if (i < 4) @(negedge clk);
    end
    $display("stall: held result=%0d for 5 cycles", held);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("consume_rdy1", int'(req1_ready), 0);
    chk("consume_valid", int'(rsp_valid), 1);
    @(negedge clk);
    chk("post_valid", int'(rsp_valid), 0);
    chk("post_busy", int'(busy), 0);
    chk("post_rdy1", int'(req1_ready), 1);
    req1_valid = 0;
    $display("release: rsp_valid=%0d req1_ready=%0d", rsp_valid, req1_ready);

    // Reset asserted in the middle of EXEC.
    @(posedge clk); #1;
    req0_valid = 1; req0_opcode = 3'b111; req0_a = 4'd6; req0_b = 4'd7;
    @(posedge clk); #1;
    req0_valid = 0;
    #2;
    chk("mid_alua", int'(alu_operand_a), 6);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_alua", int'(alu_operand_a), 0);
    chk("arst_aluop", int'(alu_opcode), 0);
    chk("arst_valid", int'(rsp_valid), 0);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("arst_norsp", seen, 0);
    @(posedge clk); #1;
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    chk("arst_tie_rdy0", int'(req0_ready), 1);
    chk("arst_tie_rdy1", int'(req1_ready), 0);
    req0_valid = 0; req1_valid = 0;
    $display("reset in EXEC: busy=%0d no response, tie to req0", busy);

    // SETTLE=3 instance: operands held three cycles, response at T+4.
    @(posedge clk); #1;
    s3_req0_valid = 1; s3_req0_opcode = 3'b011; s3_req0_a = 4'd5; s3_req0_b = 4'd5;
    @(negedge clk);
    chk("s3_rdy0", int'(s3_req0_ready), 1);
    @(posedge clk); #1;
    s3_req0_valid = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("s3_t%0d_aluop", i), int'(s3_alu_opcode), 3);
      chk($sformatf("s3_t%0d_alua", i), int'(s3_alu_operand_a), 5);
      chk($sformatf("s3_t%0d_alub", i), int'(s3_alu_operand_b), 5);
      chk($sformatf("s3_t%0d_valid", i), int'(s3_rsp_valid), 0);
    end
    @(negedge clk);
    chk("s3_t4_valid", int'(s3_rsp_valid), 1);
    chk("s3_t4_res", int'(s3_rsp_result), 9);
    chk("s3_t4_aluop", int'(s3_alu_opcode), 0);
    $display("settle3 mul: result=%0d valid=%0d", s3_rsp_result, s3_rsp_valid);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
